sync_fifo: RTL and testbench

SYNC_FIFO -- requirements
Module: sync_fifo

---
 rtl/sync_fifo.sv | 155 +++++++++++++++
 tb/tb_sync_fifo.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with registered read data, registered status
// flags derived from the next count, sticky overflow/underflow flags and a
// synchronous flush. Storage is not reset; only pointers, count and outputs are.
`timescale 1ns/1ps
module sync_fifo #(
    parameter int DATA_WIDTH = 41,
    parameter int ADDR_WIDTH = 4,
    parameter int AFULL_LVL  = (2**ADDR_WIDTH) - 2,
    parameter int AEMPTY_LVL = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  overflow,
    output logic                  underflow,
    input  logic                  err_clr
);

    localparam int DEPTH = 2**ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0]   DEPTH_C  = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   AFULL_C  = (ADDR_WIDTH+1)'(AFULL_LVL);
    localparam logic [ADDR_WIDTH:0]   AEMPTY_C = (ADDR_WIDTH+1)'(AEMPTY_LVL);
    localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH:0]   CNT_ZERO = (ADDR_WIDTH+1)'(0);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = (ADDR_WIDTH)'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ZERO = (ADDR_WIDTH)'(0);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [ADDR_WIDTH-1:0] wr_ptr_q,  wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q,  rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q,   count_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  rd_valid_q, rd_valid_d;
    logic                  full_q,    full_d;
    logic                  empty_q,   empty_d;
    logic                  afull_q,   afull_d;
    logic                  aempty_q,  aempty_d;
    logic                  ovf_q,     ovf_d;
    logic                  unf_q,     unf_d;

    logic rd_acc_s;
    logic wr_acc_s;
    logic ovf_set_s;
    logic unf_set_s;

    // Decide which requests are accepted this cycle; flush masks both requests.
    always_comb begin
        rd_acc_s  = ~flush & rd_en & ~empty_q;
        wr_acc_s  = ~flush & wr_en & (~full_q | rd_acc_s);
        ovf_set_s = ~flush & wr_en & full_q & ~rd_acc_s;
        unf_set_s = ~flush & rd_en & empty_q;
    end

    // Compute next pointers, count, read data and flags.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;

        if (flush) begin
            wr_ptr_d = PTR_ZERO;
            rd_ptr_d = PTR_ZERO;
            count_d  = CNT_ZERO;
        end else begin
            if (wr_acc_s) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (rd_acc_s) begin
                rd_ptr_d   = rd_ptr_q + PTR_ONE;
                rd_data_d  = mem_q[rd_ptr_q];
                rd_valid_d = 1'b1;
            end else begin
                rd_ptr_d   = rd_ptr_q;
                rd_data_d  = rd_data_q;
                rd_valid_d = 1'b0;
            end
            case ({wr_acc_s, rd_acc_s})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end

        full_d   = (count_d == DEPTH_C);
        empty_d  = (count_d == CNT_ZERO);
        afull_d  = (count_d >= AFULL_C);
        aempty_d = (count_d <= AEMPTY_C);

        // A new error event wins over a simultaneous clear.
        ovf_d = ovf_set_s | (ovf_q & ~err_clr);
        unf_d = unf_set_s | (unf_q & ~err_clr);
    end

    // Storage write; contents survive reset and flush.
    always_ff @(posedge clk) begin
        if (rst_n && wr_acc_s) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q   <= PTR_ZERO;
            rd_ptr_q   <= PTR_ZERO;
            count_q    <= CNT_ZERO;
            rd_data_q  <= {DATA_WIDTH{1'b0}};
            rd_valid_q <= 1'b0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            afull_q    <= 1'b0;
            aempty_q   <= 1'b1;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            afull_q    <= afull_d;
            aempty_q   <= aempty_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
        end
    end

    assign rd_data      = rd_data_q;
    assign rd_valid     = rd_valid_q;
    assign count        = count_q;
    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = afull_q;
    assign almost_empty = aempty_q;
    assign overflow     = ovf_q;
    assign underflow    = unf_q;

endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo: a queue model of the FIFO predicts each
// accepted read; the predicted word is pushed to a scoreboard at drive time
// and popped when rd_valid is expected.
`timescale 1ns/1ps
module tb_sync_fifo;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        wr_en = 1'b0;
    logic [40:0] wr_data = 41'd0;
    logic        rd_en = 1'b0;
    logic [40:0] rd_data;
    logic        rd_valid;
    logic [4:0]  count;
    logic        full, empty, almost_full, almost_empty;
    logic        overflow, underflow;
    logic        err_clr = 1'b0;

    int n_chk = 0;
    int n_err = 0;

    logic [40:0] mdl_q[$];
    logic [40:0] exp_q[$];
    logic [40:0] last_rd = 41'd0;
    logic        m_ovf = 1'b0;
    logic        m_unf = 1'b0;

    sync_fifo dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .wr_en(wr_en),
        .wr_data(wr_data), .rd_en(rd_en), .rd_data(rd_data),
        .rd_valid(rd_valid), .count(count), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty),
        .overflow(overflow), .underflow(underflow), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic check_status(input string tag);
        int sz = mdl_q.size();
        check_val({tag, ".count"}, 64'(count), 64'(sz));
        check_val({tag, ".full"}, 64'(full), 64'(sz == 16));
        check_val({tag, ".empty"}, 64'(empty), 64'(sz == 0));
        check_val({tag, ".afull"}, 64'(almost_full), 64'(sz >= 14));
        check_val({tag, ".aempty"}, 64'(almost_empty), 64'(sz <= 2));
        check_val({tag, ".ovf"}, 64'(overflow), 64'(m_ovf));
        check_val({tag, ".unf"}, 64'(underflow), 64'(m_unf));
    endtask

    // One clock of stimulus; the model predicts acceptance and output.
    task automatic step(input string tag, input logic wr, input logic [40:0] wd,
                        input logic rd, input logic clr, input logic fl);
        int  sz = mdl_q.size();
        logic rd_acc = !fl && rd && (sz > 0);
        logic wr_acc = !fl && wr && ((sz < 16) || rd_acc);
        logic ovf_set = !fl && wr && (sz == 16) && !rd_acc;
        logic unf_set = !fl && rd && (sz == 0);
        if (fl) begin
            mdl_q.delete();
        end
        if (rd_acc) exp_q.push_back(mdl_q.pop_front());
        if (wr_acc) mdl_q.push_back(wd);
        m_ovf = ovf_set | (m_ovf & !clr);
        m_unf = unf_set | (m_unf & !clr);

        wr_en = wr; wr_data = wd; rd_en = rd; err_clr = clr; flush = fl;
        @(posedge clk);
        #1;
        wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0; flush = 1'b0;

        check_val({tag, ".rd_valid"}, 64'(rd_valid), 64'(rd_acc));
        if (rd_acc) begin
            if (exp_q.size() == 0) begin
                check_val({tag, ".sb_empty"}, 64'd1, 64'd0);
            end else begin
                last_rd = exp_q.pop_front();
            end
        end
        check_val({tag, ".rd_data"}, 64'(rd_data), 64'(last_rd));
        check_status(tag);
    endtask

    // Reset for one clock with write and read requests active.
    task automatic do_reset();
        rst_n = 1'b0; wr_en = 1'b1; rd_en = 1'b1; flush = 1'b1; err_clr = 1'b0;
        wr_data = 41'h1FF;
        mdl_q.delete(); exp_q.delete();
        last_rd = 41'd0; m_ovf = 1'b0; m_unf = 1'b0;
        @(posedge clk);
        #1;
        check_val("rst.rd_valid", 64'(rd_valid), 64'd0);
        check_val("rst.rd_data", 64'(rd_data), 64'd0);
        check_status("rst");
        rst_n = 1'b1; wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0;
    endtask

    initial begin
        @(posedge clk);
        do_reset();

        // Fill 0x0..0xF, then a rejected 17th write.
        for (int i = 0; i < 16; i++) step("fill", 1'b1, 41'(i), 1'b0, 1'b0, 1'b0);
        step("ovf", 1'b1, 41'h77, 1'b0, 1'b0, 1'b0);

        // Drain in order, then a rejected 17th read.
        for (int i = 0; i < 16; i++) step("drain", 1'b0, 41'd0, 1'b1, 1'b0, 1'b0);
        step("unf", 1'b0, 41'd0, 1'b1, 1'b0, 1'b0);
        step("idle", 1'b0, 41'd0, 1'b0, 1'b0, 1'b0);
        step("clr", 1'b0, 41'd0, 1'b0, 1'b1, 1'b0);

        // Simultaneous read and write while full.
        for (int i = 0; i < 16; i++) step("fill2", 1'b1, 41'h100 + 41'(i), 1'b0, 1'b0, 1'b0);
        step("fullrw", 1'b1, 41'h1AA, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) step("drain2", 1'b0, 41'd0, 1'b1, 1'b0, 1'b0);

        // Simultaneous read and write while empty.
        step("emptyrw", 1'b1, 41'h55, 1'b1, 1'b0, 1'b0);
        step("rd55", 1'b0, 41'd0, 1'b1, 1'b0, 1'b0);
        step("clr2", 1'b0, 41'd0, 1'b0, 1'b1, 1'b0);

        // Interleaved traffic wrapping the pointers: 20 writes, 12 reads.
        for (int i = 0; i < 20; i++)
            step("wrap", 1'b1, 41'h200 + 41'(i), (i >= 2) && (i < 14), 1'b0, 1'b0);
        check_val("wrap.count8", 64'(count), 64'd8);
        step("flush", 1'b1, 41'h2FF, 1'b1, 1'b0, 1'b1);
        step("postfl_wr", 1'b1, 41'h3C, 1'b0, 1'b0, 1'b0);
        step("postfl_rd", 1'b0, 41'd0, 1'b1, 1'b0, 1'b0);

        // Overflow with simultaneous clear, bring count to 5, then reset.
        for (int i = 0; i < 16; i++) step("fill3", 1'b1, 41'h400 + 41'(i), 1'b0, 1'b0, 1'b0);
        step("ovfclr", 1'b1, 41'h4FF, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 11; i++) step("drain3", 1'b0, 41'd0, 1'b1, 1'b0, 1'b0);
        check_val("pre_rst.count5", 64'(count), 64'd5);
        check_val("pre_rst.ovf", 64'(overflow), 64'd1);
        do_reset();
        step("post_rst_wr", 1'b1, 41'h66, 1'b0, 1'b0, 1'b0);
        step("post_rst_rd", 1'b0, 41'd0, 1'b1, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
